// File: rtl/tl_uncached_mem_manager_if.sv
// Acquire / Grant / Finish channel bundle between a client and the
// uncached memory manager. The manager connects through the slave modport.
interface tl_uncached_mem_manager_if #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned CXID_BITS = 4,
  parameter int unsigned MXID_BITS = 2,
  parameter int unsigned EP_BITS   = 2
);
  // Acquire channel
  logic                 acq_valid;
  logic                 acq_ready;
  logic [EP_BITS-1:0]   acq_src;
  logic [EP_BITS-1:0]   acq_dst;
  logic [ADDR_BITS-1:0] acq_addr;
  logic [CXID_BITS-1:0] acq_client_xact_id;
  logic [DATA_BITS-1:0] acq_data;
  logic                 acq_uncached;
  logic [2:0]           acq_a_type;

  // Grant channel
  logic                 gnt_valid;
  logic                 gnt_ready;
  logic [EP_BITS-1:0]   gnt_src;
  logic [EP_BITS-1:0]   gnt_dst;
  logic [CXID_BITS-1:0] gnt_client_xact_id;
  logic [MXID_BITS-1:0] gnt_manager_xact_id;
  logic [DATA_BITS-1:0] gnt_data;
  logic [3:0]           gnt_g_type;

  // Finish channel
  logic                 fin_valid;
  logic                 fin_ready;
  logic [MXID_BITS-1:0] fin_manager_xact_id;

  // Sticky protocol-error flag
  logic                 err;

  modport master (
    output acq_valid, acq_src, acq_dst, acq_addr, acq_client_xact_id,
           acq_data, acq_uncached, acq_a_type,
    input  acq_ready,
    input  gnt_valid, gnt_src, gnt_dst, gnt_client_xact_id,
           gnt_manager_xact_id, gnt_data, gnt_g_type,
    output gnt_ready,
    output fin_valid, fin_manager_xact_id,
    input  fin_ready,
    input  err
  );

  modport slave (
    input  acq_valid, acq_src, acq_dst, acq_addr, acq_client_xact_id,
           acq_data, acq_uncached, acq_a_type,
    output acq_ready,
    output gnt_valid, gnt_src, gnt_dst, gnt_client_xact_id,
           gnt_manager_xact_id, gnt_data, gnt_g_type,
    input  gnt_ready,
    input  fin_valid, fin_manager_xact_id,
    output fin_ready,
    output err
  );
endinterface

// File: rtl/tl_uncached_mem_manager.sv
// Single-outstanding uncached memory manager: accepts one Acquire, performs
// the word read/write, returns a Grant and waits for the matching Finish.
module tl_uncached_mem_manager #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned CXID_BITS = 4,
  parameter int unsigned MXID_BITS = 2,
  parameter int unsigned EP_BITS   = 2,
  parameter int unsigned DEPTH     = 256,
  parameter logic [2:0]  A_RD      = 3'd2,
  parameter logic [2:0]  A_WR      = 3'd4,
  parameter logic [3:0]  G_RD      = 4'd3,
  parameter logic [3:0]  G_WR      = 4'd1,
  parameter logic [3:0]  G_ERR     = 4'd15
) (
  input logic clk,
  input logic rst,
  tl_uncached_mem_manager_if.slave bus
);
  localparam int unsigned OFF = $clog2(DATA_BITS / 8);
  localparam int unsigned IDX = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_GRANT, S_FINISH} state_e;

  state_e               state_q, state_d;
  logic [EP_BITS-1:0]   src_q, src_d, dst_q, dst_d;
  logic [IDX-1:0]       idx_q, idx_d;
  logic [CXID_BITS-1:0] cxid_q, cxid_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 unc_q, unc_d;
  logic [2:0]           atype_q, atype_d;
  logic [DATA_BITS-1:0] gdata_q, gdata_d;
  logic [3:0]           gtype_q, gtype_d;
  logic [MXID_BITS-1:0] mxid_q, mxid_d;
  logic                 err_q, err_d;
  logic                 mem_we;
  logic                 is_wr, is_rd;

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  // Only the word-index bits of the address select a location.
  logic unused_addr;
  assign unused_addr = ^bus.acq_addr;

  assign is_wr = unc_q && (atype_q == A_WR);
  assign is_rd = unc_q && (atype_q == A_RD);

  // State, latched Acquire fields, Grant payload, MXID counter and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      idx_q   <= '0;
      cxid_q  <= '0;
      wdata_q <= '0;
      unc_q   <= 1'b0;
      atype_q <= '0;
      gdata_q <= '0;
      gtype_q <= '0;
      mxid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      idx_q   <= idx_d;
      cxid_q  <= cxid_d;
      wdata_q <= wdata_d;
      unc_q   <= unc_d;
      atype_q <= atype_d;
      gdata_q <= gdata_d;
      gtype_q <= gtype_d;
      mxid_q  <= mxid_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath decisions for the four-phase transaction
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    idx_d   = idx_q;
    cxid_d  = cxid_q;
    wdata_d = wdata_q;
    unc_d   = unc_q;
    atype_d = atype_q;
    gdata_d = gdata_q;
    gtype_d = gtype_q;
    mxid_d  = mxid_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.acq_valid) begin
          src_d   = bus.acq_src;
          dst_d   = bus.acq_dst;
          idx_d   = bus.acq_addr[IDX+OFF-1:OFF];
          cxid_d  = bus.acq_client_xact_id;
          wdata_d = bus.acq_data;
          unc_d   = bus.acq_uncached;
          atype_d = bus.acq_a_type;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_GRANT;
        if (is_wr) begin
          mem_we  = 1'b1;
          gtype_d = G_WR;
          gdata_d = '0;
        end else if (is_rd) begin
          gtype_d = G_RD;
          gdata_d = mem_q[idx_q];
        end else begin
          gtype_d = G_ERR;
          gdata_d = '0;
          err_d   = 1'b1;
        end
      end
      S_GRANT: begin
        if (bus.gnt_ready) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (bus.fin_valid) begin
          if (bus.fin_manager_xact_id == mxid_q) begin
            mxid_d  = mxid_q + MXID_BITS'(1);
            state_d = S_IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Backing store; deliberately not reset so contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  // acq_ready is masked by rst so it reads 0 throughout reset, not just after
  assign bus.acq_ready           = (state_q == S_IDLE) && !rst;
  assign bus.gnt_valid           = (state_q == S_GRANT);
  assign bus.fin_ready           = (state_q == S_FINISH);
  assign bus.gnt_src             = dst_q;
  assign bus.gnt_dst             = src_q;
  assign bus.gnt_client_xact_id  = cxid_q;
  assign bus.gnt_manager_xact_id = mxid_q;
  assign bus.gnt_data            = gdata_q;
  assign bus.gnt_g_type          = gtype_q;
  assign bus.err                 = err_q;
endmodule

// File: tb/tb_tl_uncached_mem_manager.sv
// Randomized self-checking bench for tl_uncached_mem_manager with a
// transaction-level reference model (associative memory, MXID counter, err).
module tb_tl_uncached_mem_manager;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // reference model state
  logic [63:0] mem_m [int];
  int          exp_mxid;
  logic        exp_err;

  tl_uncached_mem_manager_if bus ();

  tl_uncached_mem_manager dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int word_index(input logic [31:0] addr);
    return int'((addr / 8) % 256);
  endfunction

  // One complete transaction: Acquire, Grant (optionally stalled), Finish
  // (optionally preceded by a mismatched Finish id).
  task automatic do_txn(input logic [1:0] src, input logic [1:0] dst,
                        input logic [31:0] addr, input logic [3:0] cxid,
                        input logic [63:0] data, input logic unc,
                        input logic [2:0] at, input int hold, input bit bad_fin);
    int          n;
    int          idx;
    logic [3:0]  e_type;
    logic [63:0] e_data;
    bit          data_known;

    @(negedge clk);
    bus.acq_valid          = 1'b1;
    bus.acq_src            = src;
    bus.acq_dst            = dst;
    bus.acq_addr           = addr;
    bus.acq_client_xact_id = cxid;
    bus.acq_data           = data;
    bus.acq_uncached       = unc;
    bus.acq_a_type         = at;
    n = 0;
    while (!bus.acq_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.acq_ready) begin
      check_eq("acq_ready_timeout", 64'(bus.acq_ready), 64'd1);
      bus.acq_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.acq_valid = 1'b0;
    check_eq("access_gnt_valid", 64'(bus.gnt_valid), 64'd0);
    check_eq("access_acq_ready", 64'(bus.acq_ready), 64'd0);

    idx        = word_index(addr);
    data_known = 1'b1;
    if (unc && at == 3'd4) begin
      mem_m[idx] = data;
      e_type = 4'd1;
      e_data = '0;
    end else if (unc && at == 3'd2) begin
      e_type = 4'd3;
      if (mem_m.exists(idx)) e_data = mem_m[idx];
      else begin
        e_data     = '0;
        data_known = 1'b0;
      end
    end else begin
      e_type  = 4'd15;
      e_data  = '0;
      exp_err = 1'b1;
    end

    @(negedge clk);
    check_eq("gnt_valid_latency", 64'(bus.gnt_valid), 64'd1);
    check_eq("gnt_g_type", 64'(bus.gnt_g_type), 64'(e_type));
    if (data_known) check_eq("gnt_data", bus.gnt_data, e_data);
    check_eq("gnt_cxid", 64'(bus.gnt_client_xact_id), 64'(cxid));
    check_eq("gnt_mxid", 64'(bus.gnt_manager_xact_id), 64'(exp_mxid));
    check_eq("gnt_dst", 64'(bus.gnt_dst), 64'(src));
    check_eq("gnt_src", 64'(bus.gnt_src), 64'(dst));
    check_eq("err_after_access", 64'(bus.err), 64'(exp_err));

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("stall_gnt_valid", 64'(bus.gnt_valid), 64'd1);
      check_eq("stall_acq_ready", 64'(bus.acq_ready), 64'd0);
      check_eq("stall_g_type", 64'(bus.gnt_g_type), 64'(e_type));
      if (data_known) check_eq("stall_gnt_data", bus.gnt_data, e_data);
      check_eq("stall_cxid", 64'(bus.gnt_client_xact_id), 64'(cxid));
      check_eq("stall_mxid", 64'(bus.gnt_manager_xact_id), 64'(exp_mxid));
    end

    bus.gnt_ready = 1'b1;
    @(negedge clk);
    bus.gnt_ready = 1'b0;
    check_eq("finish_gnt_valid", 64'(bus.gnt_valid), 64'd0);
    check_eq("finish_fin_ready", 64'(bus.fin_ready), 64'd1);

    if (bad_fin) begin
      bus.fin_valid           = 1'b1;
      bus.fin_manager_xact_id = 2'((exp_mxid + 1) % 4);
      @(negedge clk);
      bus.fin_valid = 1'b0;
      exp_err = 1'b1;
      check_eq("badfin_err", 64'(bus.err), 64'd1);
      check_eq("badfin_stay", 64'(bus.fin_ready), 64'd1);
      check_eq("badfin_acq_ready", 64'(bus.acq_ready), 64'd0);
    end

    bus.fin_valid           = 1'b1;
    bus.fin_manager_xact_id = 2'(exp_mxid);
    @(negedge clk);
    bus.fin_valid = 1'b0;
    exp_mxid = (exp_mxid + 1) % 4;
    check_eq("idle_fin_ready", 64'(bus.fin_ready), 64'd0);
    check_eq("idle_acq_ready", 64'(bus.acq_ready), 64'd1);
    check_eq("idle_mxid", 64'(bus.gnt_manager_xact_id), 64'(exp_mxid));
    check_eq("idle_err", 64'(bus.err), 64'(exp_err));
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  at;
    logic        unc;
    checks   = 0;
    failures = 0;
    exp_mxid = 0;
    exp_err  = 1'b0;
    rst                     = 1'b1;
    bus.acq_valid           = 1'b0;
    bus.acq_src             = '0;
    bus.acq_dst             = '0;
    bus.acq_addr            = '0;
    bus.acq_client_xact_id  = '0;
    bus.acq_data            = '0;
    bus.acq_uncached        = 1'b0;
    bus.acq_a_type          = '0;
    bus.gnt_ready           = 1'b0;
    bus.fin_valid           = 1'b0;
    bus.fin_manager_xact_id = '0;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_acq_ready", 64'(bus.acq_ready), 64'd0);
    check_eq("rst_gnt_valid", 64'(bus.gnt_valid), 64'd0);
    check_eq("rst_fin_ready", 64'(bus.fin_ready), 64'd0);
    check_eq("rst_err", 64'(bus.err), 64'd0);
    check_eq("rst_gnt_data", bus.gnt_data, 64'd0);
    check_eq("rst_gnt_type", 64'(bus.gnt_g_type), 64'd0);
    check_eq("rst_mxid", 64'(bus.gnt_manager_xact_id), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_acq_ready", 64'(bus.acq_ready), 64'd1);

    // Finish outside FINISH is ignored
    @(negedge clk);
    bus.fin_valid           = 1'b1;
    bus.fin_manager_xact_id = 2'd3;
    @(negedge clk);
    bus.fin_valid = 1'b0;
    check_eq("stray_fin_ready", 64'(bus.fin_ready), 64'd0);
    check_eq("stray_acq_ready", 64'(bus.acq_ready), 64'd1);
    check_eq("stray_err", 64'(bus.err), 64'd0);

    // write then read back, read held off for 5 cycles
    do_txn(2'd1, 2'd2, 32'h18, 4'd5, 64'hDEADBEEF_CAFEF00D, 1'b1, 3'd4, 0, 1'b0);
    do_txn(2'd1, 2'd2, 32'h18, 4'd6, 64'h0, 1'b1, 3'd2, 5, 1'b0);
    // mismatched Finish id then correct one
    do_txn(2'd3, 2'd0, 32'h18, 4'd7, 64'h0, 1'b1, 3'd2, 1, 1'b1);
    // four more transactions wrap the MXID counter
    for (int i = 0; i < 4; i++)
      do_txn(2'(i), 2'(3 - i), 32'h100 + 32'(i * 8), 4'(i), {32'(i), 32'hA5A5_0000},
             1'b1, 3'd4, 0, 1'b0);

    // randomized mix; upper and sub-word address bits are random noise
    for (int i = 0; i < 40; i++) begin
      a = ($urandom & 32'hFFFF_F800) | (32'($urandom_range(0, 7)) << 3) | 32'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: begin at = 3'($urandom_range(0, 7)); unc = 1'b0; end
        1: begin at = 3'd0; unc = 1'b1; end
        2, 3, 4, 5: begin at = 3'd4; unc = 1'b1; end
        default: begin at = 3'd2; unc = 1'b1; end
      endcase
      do_txn(2'($urandom), 2'($urandom), a, 4'($urandom), {$urandom, $urandom}, unc, at,
             $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    // reset during GRANT after a write has been performed
    @(negedge clk);
    bus.acq_valid          = 1'b1;
    bus.acq_src            = 2'd2;
    bus.acq_dst            = 2'd1;
    bus.acq_addr           = 32'h40;
    bus.acq_client_xact_id = 4'd9;
    bus.acq_data           = 64'h1234_5678_9ABC_DEF0;
    bus.acq_uncached       = 1'b1;
    bus.acq_a_type         = 3'd4;
    check_eq("rg_acq_ready", 64'(bus.acq_ready), 64'd1);
    @(negedge clk);
    bus.acq_valid = 1'b0;
    mem_m[word_index(32'h40)] = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    check_eq("rg_gnt_valid", 64'(bus.gnt_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("rg_rst_gnt_valid", 64'(bus.gnt_valid), 64'd0);
    check_eq("rg_rst_mxid", 64'(bus.gnt_manager_xact_id), 64'd0);
    check_eq("rg_rst_err", 64'(bus.err), 64'd0);
    check_eq("rg_rst_acq_ready", 64'(bus.acq_ready), 64'd0);
    check_eq("rg_rst_gnt_data", bus.gnt_data, 64'd0);
    exp_mxid = 0;
    exp_err  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rg_post_acq_ready", 64'(bus.acq_ready), 64'd1);
    do_txn(2'd0, 2'd3, 32'h40, 4'd1, 64'h0, 1'b1, 3'd2, 0, 1'b0);

    // illegal a_type sets err and leaves memory untouched
    do_txn(2'd1, 2'd1, 32'h40, 4'd2, 64'hFFFF_0000_FFFF_0000, 1'b1, 3'd0, 2, 1'b0);
    do_txn(2'd1, 2'd1, 32'h40, 4'd3, 64'h0, 1'b1, 3'd2, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
